a2d_spi_chan_model: RTL and testbench
=====================================

Name: a2d_spi_chan_model

Overview:
- Parametrised, synthesizable-style model of the DE0 ADC128S-type SPI A2D converter, used by the Segway testbench in place of the fixed three-channel wrapper.
- Holds NUM_CH per-channel sample registers that the bench loads through a write port.
- Each channel runs in one of two modes:
  - static: value is held.
  - ramp: value steps by a signed increment after each conversion of that channel.
- Answers the DUT's 16-bit SPI frames exactly as the part does: the channel addressed in frame N is returned in frame N+1.

Parameters:
- NUM_CH, 8, number of channels, 1..8.
- DATA_W, 12, conversion width, 8..16; result right-justified in the 16-bit frame, upper bits zero.
- RST_VAL, 0, reset value of every channel sample register.
- RAMP_SAT, 1, 1 = ramp saturates at 0 / 2^DATA_W-1; 0 = ramp wraps modulo 2^DATA_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  SPI select from DUT, active low
- SCLK  in  1  SPI clock from DUT, mode 0
- MOSI  in  1  command bits from DUT
- MISO  out  1  result bits to DUT; 1'bz while SS_n high
- wr  in  1  bench write strobe, one clk
- wr_ch  in  3  channel written
- wr_val  in  DATA_W  sample value
- wr_step  in  DATA_W  signed ramp increment
- wr_ramp  in  1  mode for wr_ch: 0 static, 1 ramp
- frame_done  out  1  one-clk pulse at each valid 16-bit frame end
- frame_err  out  1  one-clk pulse when a frame ends early or addresses ch >= NUM_CH
- cur_ch  out  3  channel to be returned in the next frame
- conv_cnt  out  16  count of valid frames, wraps

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- SS_n, SCLK and MOSI pass through 2-flop synchronisers, then edge detection.
  - Requirement: each SCLK half-period is >= 4 clk.
  - Latency: 3 clk from pin edge to internal event.
- Reset values:
  - All outputs 0; MISO z.
  - cur_ch = 0, conv_cnt = 0.
  - Channel values = RST_VAL, steps = 0, all modes static.
  - Shift registers 0; state IDLE.
- State machine IDLE -> SHIFT -> IDLE:
  - IDLE: on SS_n fall, load tx_shft = {zeros, val[cur_ch]}, clear bit counter, go to SHIFT. MISO = tx_shft[15].
  - SHIFT, SCLK rise: rx_shft <= {rx_shft[14:0], MOSI}; bit_cnt++.
  - SHIFT, SCLK fall: only after at least one rise; tx_shft shifted left, zero-filled.
  - SHIFT, SS_n rise with bit_cnt == 16: valid frame.
    - Pulse frame_done; conv_cnt++.
    - New ch = rx_shft[13:11]. If ch < NUM_CH, cur_ch <= ch. Otherwise cur_ch is unchanged and frame_err pulses along with frame_done.
    - If the returned channel is in ramp mode, its value updates by the step, per RAMP_SAT.
  - SHIFT, SS_n rise with bit_cnt != 16: discard frame. Pulse frame_err only; cur_ch, conv_cnt and values unchanged.
  - SCLK edges beyond 16 are ignored; bit_cnt saturates at 17, which makes the frame invalid.
- Ramp arithmetic:
  - Sum is formed in DATA_W+1 bits, with the step sign-extended.
  - RAMP_SAT=1: clamp to [0, 2^DATA_W-1].
  - RAMP_SAT=0: truncate.
- Write port:
  - wr updates val, step and mode of wr_ch on the next clk edge.
  - wr_ch >= NUM_CH is ignored.
  - A write during SHIFT does not alter the frame in flight, because tx_shft was already loaded.
  - Write and ramp update to the same channel in the same clk: write wins.
- Reset asserted mid-frame: everything returns to reset values immediately and MISO goes z. A frame still in progress after reset release is ignored until SS_n is seen high, then low.
- MISO is z in IDLE and tx_shft[15] in SHIFT.

Test Plan:
- Reset, write ch0=0x123, ch4=0x400; DUT-style frame with cmd ch4 -> returns 0x0123 (cur_ch=0), frame_done=1, cur_ch=4. Next frame -> returns 0x0400, conv_cnt=2.
- Ch5 ramp, val=0xFFD, step=+2, RAMP_SAT=1, three frames addressing ch5 -> returns 0xFFD, then 0xFFF, 0xFFF. Rerun with RAMP_SAT=0 -> returns 0xFFD, 0xFFF, 0x001.
- Ramp step=-0x10 (0xFF0), val=0x008, SAT -> next returned value 0x000.
- SS_n rises after 9 SCLK rises -> frame_err pulse, no frame_done, cur_ch/conv_cnt unchanged. Next full frame returns the prior channel's value.
- NUM_CH=3, cmd addresses ch6 -> frame_done and frame_err both pulse, cur_ch unchanged.
- Write ch2=0x777 mid-frame while ch2 is being returned -> current frame returns the old value, next frame returns 0x777. Assert rst_n mid-frame -> MISO=z, cur_ch=0, conv_cnt=0.

Source files
------------

// File: rtl/a2d_spi_chan_model.sv
// rtl/a2d_spi_chan_model.sv - parametrised ADC128S-style SPI A2D channel model
module a2d_spi_chan_model #(
  parameter int          NUM_CH   = 8,
  parameter int          DATA_W   = 12,
  parameter int unsigned RST_VAL  = 0,
  parameter int          RAMP_SAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr,
  input  logic [2:0]        wr_ch,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [DATA_W-1:0] wr_step,
  input  logic              wr_ramp,
  output logic              frame_done,
  output logic              frame_err,
  output logic [2:0]        cur_ch,
  output logic [15:0]       conv_cnt
);

  localparam logic [0:0]        S_IDLE  = 1'b0;
  localparam logic [0:0]        S_SHIFT = 1'b1;
  localparam logic [DATA_W-1:0] RST_W   = DATA_W'(RST_VAL);

  logic [0:0]        state;
  logic [2:0]        ss_q, sclk_q;
  logic [1:0]        mosi_q;
  logic [15:0]       tx_shft;
  logic [13:0]       rx_shft;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] val  [8];
  logic [DATA_W-1:0] step [8];
  logic [7:0]        ramp_md;

  logic              ss_fall, ss_rise, sclk_rise, sclk_fall, frame_ok;
  logic [2:0]        rx_ch;
  logic [DATA_W-1:0] cur_val, cur_step, ramp_nxt;
  logic [DATA_W:0]   sum;

  // Bits [1:0] are the synchroniser, bit [2] holds the previous synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign rx_ch     = rx_shft[13:11];
  assign frame_ok  = (state == S_SHIFT) && ss_rise && (bit_cnt == 5'd16);

  // Sum is one bit wider so overflow/underflow is visible in the top bit.
  always_comb begin
    cur_val  = val[cur_ch];
    cur_step = step[cur_ch];
    sum      = {1'b0, cur_val} + {cur_step[DATA_W-1], cur_step};
    ramp_nxt = sum[DATA_W-1:0];
    if ((RAMP_SAT != 0) && sum[DATA_W])
      ramp_nxt = cur_step[DATA_W-1] ? '0 : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      cur_ch     <= '0;
      conv_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ss_fall) begin
            tx_shft <= 16'(cur_val);
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        default: begin
          if (ss_rise) begin
            state <= S_IDLE;
            if (bit_cnt == 5'd16) begin
              frame_done <= 1'b1;
              conv_cnt   <= conv_cnt + 16'd1;
              if (int'(rx_ch) < NUM_CH) cur_ch <= rx_ch;
              else                      frame_err <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              if (bit_cnt < 5'd16) begin
                rx_shft <= {rx_shft[12:0], mosi_q[1]};
                bit_cnt <= bit_cnt + 5'd1;
              end else begin
                bit_cnt <= 5'd17;
              end
            end
            if (sclk_fall && (bit_cnt != 5'd0) && (bit_cnt <= 5'd16))
              tx_shft <= {tx_shft[14:0], 1'b0};
          end
        end
      endcase
    end
  end

  // A bench write to a channel takes priority over its ramp update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        val[i]  <= RST_W;
        step[i] <= '0;
      end
      ramp_md <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr && (wr_ch == 3'(i)) && (i < NUM_CH)) begin
          val[i]     <= wr_val;
          step[i]    <= wr_step;
          ramp_md[i] <= wr_ramp;
        end else if (frame_ok && (cur_ch == 3'(i)) && ramp_md[i]) begin
          val[i] <= ramp_nxt;
        end
      end
    end
  end

  assign MISO = (state == S_SHIFT) ? tx_shft[15] : 1'bz;

endmodule

// File: tb/tb_a2d_spi_chan_model.sv
// tb/tb_a2d_spi_chan_model.sv - scoreboard bench for a2d_spi_chan_model
module tb_a2d_spi_chan_model;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI;
  logic        wr, wr_ramp;
  logic [2:0]  wr_ch;
  logic [11:0] wr_val, wr_step;
  wire         miso_a, miso_b;
  logic        a_done, a_err, b_done, b_err;
  logic [2:0]  a_cur, b_cur;
  logic [15:0] a_cnt, b_cnt;
  logic [15:0] cap_a = '0, cap_b = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        done;
    logic        err;
    logic [15:0] data;
    logic [2:0]  cur;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  // Unit A: 8 channels, saturating ramp.  Unit B: 3 channels, wrapping ramp.
  a2d_spi_chan_model #(.NUM_CH(8), .DATA_W(12), .RST_VAL(0), .RAMP_SAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_a),
    .wr(wr), .wr_ch(wr_ch), .wr_val(wr_val), .wr_step(wr_step), .wr_ramp(wr_ramp),
    .frame_done(a_done), .frame_err(a_err), .cur_ch(a_cur), .conv_cnt(a_cnt)
  );

  a2d_spi_chan_model #(.NUM_CH(3), .DATA_W(12), .RST_VAL(0), .RAMP_SAT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_b),
    .wr(wr), .wr_ch(wr_ch), .wr_val(wr_val), .wr_step(wr_step), .wr_ramp(wr_ramp),
    .frame_done(b_done), .frame_err(b_err), .cur_ch(b_cur), .conv_cnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Master samples MISO on SCLK rise; 16 rises overwrite the whole word.
  always @(posedge SCLK) begin
    cap_a <= {cap_a[14:0], miso_a};
    cap_b <= {cap_b[14:0], miso_b};
  end

  always @(negedge clk) begin
    if (a_done || a_err) begin
      if (qa.size() == 0) chk("a_unexpected_pulse", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_done", 32'(a_done), 32'(ea.done));
        chk("a_err",  32'(a_err),  32'(ea.err));
        chk("a_cur",  32'(a_cur),  32'(ea.cur));
        chk("a_cnt",  32'(a_cnt),  32'(ea.cnt));
        if (ea.done) chk("a_data", 32'(cap_a), 32'(ea.data));
      end
    end
  end

  always @(negedge clk) begin
    if (b_done || b_err) begin
      if (qb.size() == 0) chk("b_unexpected_pulse", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_done", 32'(b_done), 32'(eb.done));
        chk("b_err",  32'(b_err),  32'(eb.err));
        chk("b_cur",  32'(b_cur),  32'(eb.cur));
        chk("b_cnt",  32'(b_cnt),  32'(eb.cnt));
        if (eb.done) chk("b_data", 32'(cap_b), 32'(eb.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_v(input logic [11:0] da, input logic [11:0] db, input logic era,
                       input logic erb, input logic [2:0] ca, input logic [2:0] cb,
                       input logic [15:0] n);
    exp_t e;
    e.done = 1'b1; e.err = era; e.data = {4'h0, da}; e.cur = ca; e.cnt = n;
    qa.push_back(e);
    e.err = erb; e.data = {4'h0, db}; e.cur = cb;
    qb.push_back(e);
  endtask

  task automatic exp_bad(input logic [2:0] c, input logic [15:0] n);
    exp_t e;
    e.done = 1'b0; e.err = 1'b1; e.data = '0; e.cur = c; e.cnt = n;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic write(input logic [2:0] ch, input logic [11:0] v, input logic [11:0] s,
                       input logic rmp);
    wr = 1'b1; wr_ch = ch; wr_val = v; wr_step = s; wr_ramp = rmp;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // mode 1: rewrite ch2 mid-frame; mode 2: pulse reset mid-frame
  task automatic spi_frame(input logic [2:0] ch, input int nbits, input int mode);
    logic [15:0] cmd;
    cmd  = {2'b00, ch, 11'h000};
    SS_n = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      MOSI = cmd[15-b];
      idle(HALF);
      SCLK = 1'b1;
      idle(HALF);
      SCLK = 1'b0;
      if (b == 5 && mode == 1) write(3'd2, 12'h777, 12'h000, 1'b0);
      if (b == 5 && mode == 2) begin
        rst_n = 1'b0;
        idle(2);
        chk("rst_a_cur", 32'(a_cur), 32'd0);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_b_cur", 32'(b_cur), 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        rst_n = 1'b1;
      end
    end
    idle(HALF);
    SS_n = 1'b1;
    idle(2 * HALF);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wr = 1'b0; wr_ch = '0; wr_val = '0; wr_step = '0; wr_ramp = 1'b0;
    idle(5);
    chk("reset_a_done", 32'(a_done), 32'd0);
    chk("reset_a_err",  32'(a_err),  32'd0);
    chk("reset_a_cur",  32'(a_cur),  32'd0);
    chk("reset_a_cnt",  32'(a_cnt),  32'd0);
    chk("reset_b_cur",  32'(b_cur),  32'd0);
    chk("reset_b_cnt",  32'(b_cnt),  32'd0);
    rst_n = 1'b1;
    idle(5);

    write(3'd0, 12'h123, 12'h000, 1'b0);
    write(3'd4, 12'h400, 12'h000, 1'b0);
    exp_v(12'h123, 12'h123, 0, 1, 3'd4, 3'd0, 16'd1); spi_frame(3'd4, 16, 0);
    exp_v(12'h400, 12'h123, 0, 0, 3'd0, 3'd0, 16'd2); spi_frame(3'd0, 16, 0);

    write(3'd2, 12'hFFD, 12'h002, 1'b1);
    exp_v(12'h123, 12'h123, 0, 0, 3'd2, 3'd2, 16'd3); spi_frame(3'd2, 16, 0);
    exp_v(12'hFFD, 12'hFFD, 0, 0, 3'd2, 3'd2, 16'd4); spi_frame(3'd2, 16, 0);
    exp_v(12'hFFF, 12'hFFF, 0, 0, 3'd2, 3'd2, 16'd5); spi_frame(3'd2, 16, 0);
    exp_v(12'hFFF, 12'h001, 0, 0, 3'd2, 3'd2, 16'd6); spi_frame(3'd2, 16, 0);

    write(3'd1, 12'h008, 12'hFF0, 1'b1);
    exp_v(12'hFFF, 12'h003, 0, 0, 3'd1, 3'd1, 16'd7); spi_frame(3'd1, 16, 0);
    exp_v(12'h008, 12'h008, 0, 0, 3'd1, 3'd1, 16'd8); spi_frame(3'd1, 16, 0);
    exp_v(12'h000, 12'hFF8, 0, 0, 3'd0, 3'd0, 16'd9); spi_frame(3'd0, 16, 0);

    exp_bad(3'd0, 16'd9); spi_frame(3'd2, 9, 0);
    exp_v(12'h123, 12'h123, 0, 1, 3'd6, 3'd0, 16'd10); spi_frame(3'd6, 16, 0);
    exp_v(12'h000, 12'h123, 0, 0, 3'd2, 3'd2, 16'd11); spi_frame(3'd2, 16, 0);

    exp_v(12'hFFF, 12'h005, 0, 0, 3'd2, 3'd2, 16'd12); spi_frame(3'd2, 16, 1);
    exp_v(12'h777, 12'h777, 0, 0, 3'd0, 3'd0, 16'd13); spi_frame(3'd0, 16, 0);

    spi_frame(3'd3, 16, 2);
    exp_v(12'h000, 12'h000, 0, 0, 3'd0, 3'd0, 16'd1); spi_frame(3'd0, 16, 0);

    idle(20);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
